// File: rtl/arb_client_bank_if.sv
// Bus between the arbiter client bank and its job source and arbiter.
// The client bank uses the master modport; the job source and arbiter side use slave.
interface arb_client_bank_if #(
    parameter int LEN_W = 4
);
    logic [3:0]         job_valid;
    logic [4*LEN_W-1:0] job_len;
    logic [3:0]         job_ready;
    logic [3:0]         REQ;
    logic [3:0]         GNT;
    logic [3:0]         beat_valid;
    logic [3:0]         done;
    logic [3:0]         starve;
    logic [3:0]         starve_clr;
    logic               gnt_err;

    modport master (
        input  job_valid, job_len, GNT, starve_clr,
        output job_ready, REQ, beat_valid, done, starve, gnt_err
    );

    modport slave (
        output job_valid, job_len, GNT, starve_clr,
        input  job_ready, REQ, beat_valid, done, starve, gnt_err
    );
endinterface

// File: rtl/arb_client_bank.sv
// Requester side of a 4-way arbiter: one burst job per channel, beat counting,
// starvation tracking and a sticky grant-protocol error flag.
module arb_client_bank #(
    parameter int LEN_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    arb_client_bank_if.master    bus
);
    localparam int          CNT_W    = LEN_W + 1;
    localparam logic [7:0]  WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    logic [3:0] idle_gnt;
    logic       multi_gnt;
    logic       gnt_err_reg;
    logic       gnt_err_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            state_t             state_reg;
            state_t             state_next;
            logic [CNT_W-1:0]   remaining_reg;
            logic [CNT_W-1:0]   remaining_next;
            logic [7:0]         wait_reg;
            logic [7:0]         wait_next;
            logic               starve_reg;
            logic               starve_next;
            logic               starve_set;
            logic               gnt;
            logic [LEN_W-1:0]   len;
            logic               ready_c;
            logic               req_c;
            logic               beat_c;
            logic               done_c;

            assign gnt = bus.GNT[gi];
            assign len = bus.job_len[gi*LEN_W +: LEN_W];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_reg     <= IDLE;
                    remaining_reg <= '0;
                    wait_reg      <= '0;
                    starve_reg    <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    remaining_reg <= remaining_next;
                    wait_reg      <= wait_next;
                    starve_reg    <= starve_next;
                end
            end

            // A missing grant just holds the burst; the wait counter tracks how long.
            always_comb begin
                state_next     = state_reg;
                remaining_next = remaining_reg;
                wait_next      = '0;
                starve_set     = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (bus.job_valid[gi]) begin
                            state_next     = ACTIVE;
                            remaining_next = {1'b0, len} + CNT_W'(1);
                        end
                    end
                    ACTIVE: begin
                        if (gnt) begin
                            remaining_next = remaining_reg - CNT_W'(1);
                            if (remaining_reg == CNT_W'(1)) begin
                                state_next = GAP;
                            end
                        end else begin
                            wait_next  = (wait_reg == WAIT_LIM) ? wait_reg : wait_reg + 8'd1;
                            starve_set = (wait_next == WAIT_LIM);
                        end
                    end
                    GAP: begin
                        state_next = IDLE;
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
                starve_next = starve_set | (starve_reg & ~bus.starve_clr[gi]);
            end

            // GAP swallows the stale grant that follows the final beat.
            always_comb begin
                ready_c = 1'b0;
                req_c   = 1'b0;
                beat_c  = 1'b0;
                done_c  = 1'b0;
                case (state_reg)
                    IDLE: begin
                        ready_c = 1'b1;
                    end
                    ACTIVE: begin
                        req_c  = 1'b1;
                        beat_c = gnt;
                        done_c = gnt && (remaining_reg == CNT_W'(1));
                    end
                    default: begin
                    end
                endcase
            end

            assign bus.job_ready[gi]  = ready_c;
            assign bus.REQ[gi]        = req_c;
            assign bus.beat_valid[gi] = beat_c;
            assign bus.done[gi]       = done_c;
            assign bus.starve[gi]     = starve_reg;
            assign idle_gnt[gi]       = (state_reg == IDLE) && gnt;
        end
    endgenerate

    assign multi_gnt    = (bus.GNT & (bus.GNT - 4'd1)) != 4'd0;
    assign gnt_err_next = gnt_err_reg | multi_gnt | (|idle_gnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_err_reg <= 1'b0;
        end else begin
            gnt_err_reg <= gnt_err_next;
        end
    end

    assign bus.gnt_err = gnt_err_reg;
endmodule

// File: tb/tb_arb_client_bank.sv
// Bench for arb_client_bank: fixed-priority arbiter model (3>1>0>2), per-channel
// expected-beat scoreboard drained by a monitor, plus directed timing checks.
module tb_arb_client_bank;
    logic clk;
    logic reset;
    arb_client_bank_if #(.LEN_W(4)) bus ();

    arb_client_bank #(.LEN_W(4), .WAIT_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[4][$];

    logic [3:0] arb_gnt;
    logic       force_en;
    logic [3:0] force_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] prio(input logic [3:0] r);
        if (r[3])      return 4'b1000;
        else if (r[1]) return 4'b0010;
        else if (r[0]) return 4'b0001;
        else if (r[2]) return 4'b0100;
        else           return 4'b0000;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) arb_gnt <= 4'b0000;
        else        arb_gnt <= prio(bus.REQ);
    end

    assign bus.GNT = force_en ? force_val : arb_gnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a job for one edge and queue its expected beats (done on the last).
    task automatic offer(input int ch, input int len);
        bus.job_valid[ch] = 1'b1;
        bus.job_len[ch*4 +: 4] = 4'(len);
        for (int k = 0; k <= len; k++) exp_q[ch].push_back(k == len);
        tick(1);
        bus.job_valid[ch] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                if (bus.beat_valid[c]) begin
                    if (exp_q[c].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL beat_ch%0d: unexpected beat, expected none at %0t", c, $time);
                    end else begin
                        bit e;
                        e = exp_q[c].pop_front();
                        check($sformatf("done_ch%0d", c), 16'(bus.done[c]), 16'(e));
                    end
                end else if (bus.done[c]) begin
                    check($sformatf("done_nobeat_ch%0d", c), 16'(bus.done[c]), 16'h0);
                end
            end
        end
    end

    initial begin
        int cnt;
        reset = 1'b0;
        force_en = 1'b0;
        force_val = 4'b0000;
        bus.job_valid = 4'b0000;
        bus.job_len = '0;
        bus.starve_clr = 4'b0000;
        tick(2);
        check("rst_req", 16'(bus.REQ), 16'h0);
        check("rst_ready", 16'(bus.job_ready), 16'hf);
        check("rst_starve", 16'(bus.starve), 16'h0);
        check("rst_gnt_err", 16'(bus.gnt_err), 16'h0);
        check("rst_beat", 16'(bus.beat_valid), 16'h0);
        reset = 1'b1;
        tick(1);

        // Single job on ch1, len 3
        offer(1, 3);
        check("single_req", 16'(bus.REQ), 16'h2);
        check("single_ready", 16'(bus.job_ready), 16'hd);
        tick(1);
        check("single_beat1", 16'(bus.beat_valid), 16'h2);
        check("single_done_early", 16'(bus.done), 16'h0);
        tick(3);
        check("single_done", 16'(bus.done), 16'h2);
        tick(1);
        check("single_gap_req", 16'(bus.REQ), 16'h0);
        check("single_gap_ready", 16'(bus.job_ready), 16'hd);
        check("single_gap_beat", 16'(bus.beat_valid), 16'h0);
        tick(1);
        check("single_ready_back", 16'(bus.job_ready), 16'hf);
        check("single_gnt_err", 16'(bus.gnt_err), 16'h0);
        tick(2);

        // Preemption: ch0 len 5, ch3 len 1 arrives after 2 ch0 beats
        offer(0, 5);
        tick(1);
        check("pre_beat1", 16'(bus.beat_valid), 16'h1);
        offer(3, 1);
        check("pre_beat2", 16'(bus.beat_valid), 16'h1);
        tick(1);
        check("pre_ch3_b1", 16'(bus.beat_valid), 16'h8);
        tick(1);
        check("pre_ch3_done", 16'(bus.done), 16'h8);
        tick(1);
        check("pre_stale", 16'(bus.beat_valid), 16'h0);
        tick(1);
        check("pre_resume", 16'(bus.beat_valid), 16'h1);
        tick(3);
        check("pre_ch0_done", 16'(bus.done), 16'h1);
        tick(3);
        check("pre_starve", 16'(bus.starve), 16'h0);
        check("pre_gnt_err", 16'(bus.gnt_err), 16'h0);

        // Starvation: ch3 long burst holds off ch2
        offer(3, 7);
        offer(2, 1);
        tick(3);
        check("stv_not_yet", 16'(bus.starve), 16'h0);
        tick(1);
        check("stv_set", 16'(bus.starve), 16'h4);
        bus.starve_clr = 4'b0100;
        tick(1);
        bus.starve_clr = 4'b0000;
        check("stv_set_wins", 16'(bus.starve), 16'h4);
        tick(4);
        check("stv_ch2_granted", 16'(bus.beat_valid), 16'h4);
        bus.starve_clr = 4'b0100;
        tick(1);
        bus.starve_clr = 4'b0000;
        check("stv_cleared", 16'(bus.starve), 16'h0);
        tick(3);

        // Max length: 16 beats
        offer(1, 15);
        cnt = 0;
        for (int k = 0; k < 18; k++) begin
            tick(1);
            if (bus.beat_valid[1]) cnt++;
        end
        check("max_len_beats", 16'(cnt), 16'd16);
        tick(2);

        // Min length: 1 beat, done in the same cycle
        offer(0, 0);
        tick(1);
        check("min_len_beat", 16'(bus.beat_valid), 16'h1);
        check("min_len_done", 16'(bus.done), 16'h1);
        tick(3);
        check("clean_gnt_err", 16'(bus.gnt_err), 16'h0);

        // Protocol errors
        force_en = 1'b1;
        force_val = 4'b0011;
        tick(1);
        force_en = 1'b0;
        check("err_multi", 16'(bus.gnt_err), 16'h1);
        tick(3);
        check("err_sticky", 16'(bus.gnt_err), 16'h1);
        do_reset();
        check("err_reset_clr", 16'(bus.gnt_err), 16'h0);
        force_en = 1'b1;
        force_val = 4'b0001;
        tick(1);
        force_en = 1'b0;
        check("err_idle_gnt", 16'(bus.gnt_err), 16'h1);
        tick(3);
        check("err_idle_sticky", 16'(bus.gnt_err), 16'h1);

        // Reset mid-burst with ch1 at remaining=2
        offer(1, 7);
        tick(7);
        #2;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        #1;
        check("mid_rst_req", 16'(bus.REQ), 16'h0);
        check("mid_rst_ready", 16'(bus.job_ready), 16'hf);
        tick(2);
        check("mid_rst_done", 16'(bus.done), 16'h0);
        reset = 1'b1;
        tick(1);
        check("mid_rst_gnt_err", 16'(bus.gnt_err), 16'h0);
        check("mid_rst_ready2", 16'(bus.job_ready), 16'hf);
        offer(1, 2);
        check("mid_rst_new_req", 16'(bus.REQ), 16'h2);
        tick(3);
        check("mid_rst_new_done", 16'(bus.done), 16'h2);
        tick(3);

        for (int c = 0; c < 4; c++)
            check($sformatf("queue_empty_ch%0d", c), 16'(exp_q[c].size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
